// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encodings, BCD limits and binary-to-BCD helper
package stopwatch_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_LAP   = 2'd3;
  localparam logic [3:0] CS_MAX       = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  function automatic logic [7:0] bin2bcd2(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
endpackage

// File: rtl/bcd_digit_cnt.sv
// bcd_digit_cnt: one BCD digit counting 0..MAX, carry out when it rolls over
//   clk, rst (async, active-low), clr (sync clear, overrides inc), inc
//   q[3:0] digit value, carry = inc while q is at MAX
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] MAX = CS_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);
  logic [3:0] q_q, q_d;
  assign carry = inc & (q_q == MAX);
  assign q     = q_q;
  always_comb q_d = (clr | carry) ? 4'd0 : inc ? q_q + 4'd1 : q_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop/lap/clear sequencer driving a BCD MM:SS.cc counter
//   clk, rst (async, active-low), en_100hz (10 ms tick), btn_ss / btn_lc (one-cycle pulses)
//   disp_cs / disp_sec / disp_min: two BCD digits each; running, lap_active, overflow (sticky)
//   STOPWATCH_LAP_EN: enables the LAP state and snapshot; otherwise btn_lc only clears from PAUSE
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int MIN_MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_100hz,
  input  logic       btn_ss,
  input  logic       btn_lc,
  output logic [7:0] disp_cs,
  output logic [7:0] disp_sec,
  output logic [7:0] disp_min,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif
  localparam logic [7:0] MIN_BCD = bin2bcd2(MIN_MAX);
  logic [1:0] state_q, state_d;
  logic ovf_q, ovf_d;
  logic [3:0] cs0, cs1, s0, s1, m0, m1;
  logic c0, c1, c2, c3, c4, unused_min_carry;
  logic tick, clear, wrap;
  logic [23:0] live;
  assign running = (state_q == ST_RUN) | (state_q == ST_LAP);
  assign tick    = en_100hz & running;
  assign clear   = (state_q == ST_PAUSE) & btn_lc & ~btn_ss;
  // Minutes digits count freely to 99; the wrap at MIN_MAX:59.99 is forced by a sync clear.
  assign wrap    = tick & (cs0 == CS_MAX) & (cs1 == CS_MAX) & (s0 == CS_MAX)
                 & (s1 == SEC_TENS_MAX) & ({m1, m0} == MIN_BCD);
  assign live    = {m1, m0, s1, s0, cs1, cs0};
  bcd_digit_cnt #(.MAX(CS_MAX))       u_cs0 (.clk(clk), .rst(rst), .clr(clear | wrap), .inc(tick), .q(cs0), .carry(c0));
  bcd_digit_cnt #(.MAX(CS_MAX))       u_cs1 (.clk(clk), .rst(rst), .clr(clear | wrap), .inc(c0),   .q(cs1), .carry(c1));
  bcd_digit_cnt #(.MAX(CS_MAX))       u_s0  (.clk(clk), .rst(rst), .clr(clear | wrap), .inc(c1),   .q(s0),  .carry(c2));
  bcd_digit_cnt #(.MAX(SEC_TENS_MAX)) u_s1  (.clk(clk), .rst(rst), .clr(clear | wrap), .inc(c2),   .q(s1),  .carry(c3));
  bcd_digit_cnt #(.MAX(CS_MAX))       u_m0  (.clk(clk), .rst(rst), .clr(clear | wrap), .inc(c3),   .q(m0),  .carry(c4));
  bcd_digit_cnt #(.MAX(CS_MAX))       u_m1  (.clk(clk), .rst(rst), .clr(clear | wrap), .inc(c4),   .q(m1),  .carry(unused_min_carry));
  // btn_ss has priority; a simultaneous btn_lc is dropped.
  always_comb begin
    state_d = state_q;
    if (btn_ss)      state_d = running ? ST_PAUSE : ST_RUN;
    else if (btn_lc) state_d = (state_q == ST_PAUSE) ? ST_IDLE :
                               (state_q == ST_LAP) ? ST_RUN :
                               (LAP_EN && state_q == ST_RUN) ? ST_LAP : state_q;
  end
  always_comb ovf_d = clear ? 1'b0 : wrap ? 1'b1 : ovf_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= ST_IDLE;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  assign overflow = ovf_q;
`ifdef STOPWATCH_LAP_EN
  logic [23:0] snap_q, snap_d;
  // Snapshot takes the pre-increment counter value of the RUN->LAP edge.
  always_comb snap_d = (state_q == ST_RUN && state_d == ST_LAP) ? live : snap_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) snap_q <= '0;
    else      snap_q <= snap_d;
  assign lap_active = state_q == ST_LAP;
  assign {disp_min, disp_sec, disp_cs} = lap_active ? snap_q : live;
`else
  assign lap_active = 1'b0;
  assign {disp_min, disp_sec, disp_cs} = live;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: scoreboard bench with a centisecond-integer reference model
module tb_stopwatch_ctrl;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif
  localparam int MINM   = 1;
  localparam int PERIOD = (MINM + 1) * 6000;
  typedef struct packed {
    logic [7:0] cs, sec, mn;
    logic run, lap, ovf;
  } obs_t;
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_LAP} mst_t;
  logic clk = 0, rst = 1, en_100hz = 0, btn_ss = 0, btn_lc = 0;
  logic [7:0] disp_cs, disp_sec, disp_min;
  logic running, lap_active, overflow;
  int passed = 0, total = 0;
  mst_t m_st = M_IDLE;
  int m_t = 0, m_snap = 0;
  bit m_ovf = 0;
  obs_t q[$];
  obs_t mon_e;
  stopwatch_ctrl #(.MIN_MAX(MINM)) dut (
    .clk(clk), .rst(rst), .en_100hz(en_100hz), .btn_ss(btn_ss), .btn_lc(btn_lc),
    .disp_cs(disp_cs), .disp_sec(disp_sec), .disp_min(disp_min),
    .running(running), .lap_active(lap_active), .overflow(overflow)
  );
  always #5 clk = ~clk;
  function automatic obs_t dut_obs();
    return {disp_cs, disp_sec, disp_min, running, lap_active, overflow};
  endfunction
  function automatic logic [7:0] bcd(input int x);
    logic [7:0] r;
    r[7:4] = 4'(x / 10);
    r[3:0] = 4'(x % 10);
    return r;
  endfunction
  function automatic obs_t model_obs();
    int v;
    v = (m_st == M_LAP) ? m_snap : m_t;
    return {bcd(v % 100), bcd((v / 100) % 60), bcd(v / 6000),
            m_st == M_RUN || m_st == M_LAP, m_st == M_LAP, m_ovf};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic model_step(input bit ss, input bit lc, input bit tk);
    bit counting;
    counting = tk && (m_st == M_RUN || m_st == M_LAP);
    if (ss) m_st = (m_st == M_RUN || m_st == M_LAP) ? M_PAUSE : M_RUN;
    else if (lc) begin
      if (m_st == M_PAUSE) begin
        m_st = M_IDLE;
        m_t = 0;
        m_ovf = 0;
      end else if (m_st == M_LAP) m_st = M_RUN;
      else if (m_st == M_RUN && LAP_EN) begin
        m_st = M_LAP;
        m_snap = m_t;
      end
    end
    if (counting) begin
      m_t++;
      if (m_t == PERIOD) begin
        m_t = 0;
        m_ovf = 1;
      end
    end
  endtask
  task automatic model_reset();
    m_st = M_IDLE;
    m_t = 0;
    m_snap = 0;
    m_ovf = 0;
  endtask
  task automatic step(input bit ss, input bit lc, input bit tk);
    @(posedge clk);
    #2;
    btn_ss = ss;
    btn_lc = lc;
    en_100hz = tk;
    model_step(ss, lc, tk);
    q.push_back(model_obs());
  endtask
  task automatic to_idle();
    if (m_st != M_IDLE) begin
      if (m_st != M_PAUSE) step(1, 0, 0);
      step(0, 1, 0);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("scoreboard", dut_obs(), mon_e);
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    #3 rst = 0;
    #1 chk("reset", dut_obs(), 0);
    @(posedge clk);
    #2 rst = 1;
    // 1: 150 ticks then stop
    step(1, 0, 0);
    repeat (150) step(0, 0, 1);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("t1_pause", dut_obs(), {8'h50, 8'h01, 8'h00, 3'b000});
    // 2: start with a coincident tick
    to_idle();
    step(1, 0, 1);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("t2_start_tick", disp_cs, 8'h01);
    // 3: lap freeze and release
    to_idle();
    step(1, 0, 0);
    repeat (42) step(0, 0, 1);
    step(0, 1, 0);
    repeat (30) step(0, 0, 1);
    step(0, 0, 0);
    chk("t3_lap", {disp_cs, disp_sec, lap_active}, LAP_EN ? {8'h42, 8'h00, 1'b1} : {8'h72, 8'h00, 1'b0});
    step(0, 1, 0);
    step(0, 0, 0);
    chk("t3_live", {disp_cs, lap_active}, {8'h72, 1'b0});
    // 5: stop + lap + tick together in RUN
    step(1, 1, 1);
    step(0, 0, 0);
    chk("t5_ss_wins", {disp_cs, running, lap_active}, {8'h73, 2'b00});
    // 6: async reset mid-count
    to_idle();
    step(1, 0, 0);
    repeat (1234) step(0, 0, 1);
    step(0, 0, 0);
    chk("t6_pre", {disp_sec, disp_cs}, 16'h1234);
    @(posedge clk);
    #2;
    en_100hz = 1;
    rst = 0;
    #1 chk("t6_async", dut_obs(), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1;
    repeat (5) step(0, 0, 1);
    step(0, 0, 0);
    chk("t6_idle", dut_obs(), 0);
    step(1, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("t6_restart", disp_cs, 8'h01);
    // 4: wrap past MIN_MAX:59.99
    to_idle();
    step(1, 0, 0);
    repeat (PERIOD) step(0, 0, 1);
    step(0, 0, 0);
    chk("t4_wrap", dut_obs(), {24'h0, 3'b101});
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("t4_clear", dut_obs(), 0);
    // random traffic
    repeat (3000) step($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 50);
    @(posedge clk);
    #3;
    chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
